// File: rtl/clockdivider_prog.sv
// Multi-channel programmable clock divider. Each channel runs its own divisor and mode,
// with config staged through a valid/ready port and applied only at a period boundary.
module clockdivider_prog #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEFAULT_DIV  = 3,
    parameter bit          DEFAULT_MODE = 1'b0,
    localparam int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                cfg_mode,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic [WIDTH-1:0]    cnt_q        [CHANNELS];
    logic [WIDTH-1:0]    cnt_d        [CHANNELS];
    logic [WIDTH-1:0]    div_q        [CHANNELS];
    logic [WIDTH-1:0]    div_d        [CHANNELS];
    logic [WIDTH-1:0]    shadow_div_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_div_d [CHANNELS];
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] shadow_mode_q, shadow_mode_d;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] clk_out_q, clk_out_d;
    logic [CHANNELS-1:0] tick_q, tick_d;

    logic [CHANNELS-1:0] accept, terminal, apply, eff_mode;

    // Out-of-range channels match no slot, so they are always ready and silently dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending_q[i];
            end
        end
    end

    always_comb begin
        accept   = '0;
        terminal = '0;
        apply    = '0;
        eff_mode = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i]   = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
            terminal[i] = en[i] && (cnt_q[i] == div_q[i]);
            // Accept needs pending low and apply needs it high, so the two never coincide.
            apply[i]    = pending_q[i] && (terminal[i] || !en[i]);
            eff_mode[i] = apply[i] ? shadow_mode_q[i] : mode_q[i];
        end
    end

    always_comb begin
        cnt_d         = cnt_q;
        div_d         = div_q;
        shadow_div_d  = shadow_div_q;
        mode_d        = mode_q;
        shadow_mode_d = shadow_mode_q;
        pending_d     = pending_q;
        clk_out_d     = clk_out_q;
        tick_d        = tick_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!en[i]) begin
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                tick_d[i]    = 1'b0;
            end else if (terminal[i]) begin
                cnt_d[i]     = '0;
                tick_d[i]    = 1'b1;
                clk_out_d[i] = eff_mode[i] ? 1'b1 : !clk_out_q[i];
            end else begin
                cnt_d[i]     = cnt_q[i] + WIDTH'(1);
                tick_d[i]    = 1'b0;
                clk_out_d[i] = mode_q[i] ? 1'b0 : clk_out_q[i];
            end

            if (apply[i]) begin
                div_d[i]     = shadow_div_q[i];
                mode_d[i]    = shadow_mode_q[i];
                pending_d[i] = 1'b0;
            end else if (accept[i]) begin
                shadow_div_d[i]  = cfg_div;
                shadow_mode_d[i] = cfg_mode;
                pending_d[i]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]        <= '0;
                div_q[i]        <= WIDTH'(DEFAULT_DIV);
                shadow_div_q[i] <= '0;
            end
            mode_q        <= {CHANNELS{DEFAULT_MODE}};
            shadow_mode_q <= '0;
            pending_q     <= '0;
            clk_out_q     <= '0;
            tick_q        <= '0;
        end else begin
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            shadow_div_q  <= shadow_div_d;
            mode_q        <= mode_d;
            shadow_mode_q <= shadow_mode_d;
            pending_q     <= pending_d;
            clk_out_q     <= clk_out_d;
            tick_q        <= tick_d;
        end
    end

    assign pending = pending_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clockdivider_prog.sv
// Scoreboard bench for clockdivider_prog: directed config/enable stimulus queues
// hand-computed per-cycle expectations that a negedge monitor checks.
module tb_clockdivider_prog;

    localparam int CH = 3;
    localparam int SIG_CLK = 0, SIG_TICK = 1, SIG_PEND = 2, SIG_RDY = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] en;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [7:0]    cfg_div;
    logic          cfg_mode;
    logic [CH-1:0] pending;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    clockdivider_prog #(
        .CHANNELS (CH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .pending   (pending),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         sig;
        logic [2:0] mask;
        logic [2:0] val;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic ex(input int c, input int sig, input logic [2:0] m, input logic [2:0] v,
                      input string n);
        exp_t e;
        e.cyc  = c;
        e.sig  = sig;
        e.mask = m;
        e.val  = v;
        e.name = n;
        q.push_back(e);
    endtask

    function automatic logic [2:0] sample(input int sig);
        case (sig)
            SIG_CLK:  return clk_out;
            SIG_TICK: return tick;
            SIG_PEND: return pending;
            default:  return {2'b00, cfg_ready};
        endcase
    endfunction

    exp_t       me;
    logic [2:0] mact;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            me = q.pop_front();
            n_tests++;
            if (me.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: check due at cycle %0d not sampled (now %0d)",
                         me.name, me.cyc, cyc);
            end else begin
                mact = sample(me.sig) & me.mask;
                if (mact !== me.val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %b, expected %b (mask %b)",
                             me.name, cyc, mact, me.val, me.mask);
                end
            end
        end
    end

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input logic v, input logic [1:0] ch, input logic [7:0] d, input logic m);
        cfg_valid = v;
        cfg_ch    = ch;
        cfg_div   = d;
        cfg_mode  = m;
    endtask

    int b, c;

    initial begin
        rst = 1'b1;
        en  = '0;
        cfg(1'b0, 2'd0, 8'd0, 1'b0);
        at(3);
        rst = 1'b0;
        en  = 3'b111;
        b   = cyc;

        // Default div 3, mode 0: toggle every 4 edges, all channels in phase
        ex(b,     SIG_CLK,  3'b111, 3'b000, "rst_clk");
        ex(b,     SIG_TICK, 3'b111, 3'b000, "rst_tick");
        ex(b,     SIG_PEND, 3'b111, 3'b000, "rst_pend");
        ex(b + 3, SIG_CLK,  3'b111, 3'b000, "pre_clk");
        ex(b + 3, SIG_TICK, 3'b111, 3'b000, "pre_tick");
        ex(b + 4, SIG_CLK,  3'b111, 3'b111, "first_toggle");
        ex(b + 4, SIG_TICK, 3'b111, 3'b111, "first_tick");
        ex(b + 5, SIG_CLK,  3'b111, 3'b111, "hold_high");
        ex(b + 5, SIG_TICK, 3'b111, 3'b000, "tick_one_cycle");
        ex(b + 8, SIG_CLK,  3'b111, 3'b000, "second_toggle");
        ex(b + 8, SIG_TICK, 3'b111, 3'b111, "second_tick");

        // ch0 -> div 1 written mid-period (cnt=1)
        at(b + 9);
        cfg(1'b1, 2'd0, 8'd1, 1'b0);
        ex(b + 9,  SIG_RDY,  3'b001, 3'b001, "rdy_free");
        ex(b + 10, SIG_PEND, 3'b111, 3'b001, "pend0_set");
        ex(b + 10, SIG_RDY,  3'b001, 3'b000, "rdy_busy");
        ex(b + 11, SIG_CLK,  3'b111, 3'b000, "old_period_holds");
        ex(b + 12, SIG_CLK,  3'b111, 3'b111, "apply_toggle");
        ex(b + 12, SIG_PEND, 3'b111, 3'b000, "apply_clear");
        ex(b + 13, SIG_TICK, 3'b111, 3'b000, "post_apply_tick");
        ex(b + 14, SIG_CLK,  3'b111, 3'b110, "ch0_fast_clk");
        ex(b + 14, SIG_TICK, 3'b111, 3'b001, "ch0_fast_tick");
        ex(b + 16, SIG_CLK,  3'b111, 3'b001, "mixed_clk");
        ex(b + 16, SIG_TICK, 3'b111, 3'b111, "mixed_tick");
        at(b + 10);
        cfg_valid = 1'b0;

        // ch1 -> div 0, pulse mode
        at(b + 16);
        cfg(1'b1, 2'd1, 8'd0, 1'b1);
        ex(b + 17, SIG_PEND, 3'b010, 3'b010, "pend1_set");
        ex(b + 19, SIG_TICK, 3'b010, 3'b000, "ch1_old_tick");
        ex(b + 19, SIG_CLK,  3'b010, 3'b000, "ch1_old_clk");
        ex(b + 20, SIG_PEND, 3'b010, 3'b000, "pend1_clear");
        ex(b + 20, SIG_TICK, 3'b010, 3'b010, "ch1_apply_tick");
        ex(b + 20, SIG_CLK,  3'b010, 3'b010, "ch1_apply_clk");
        ex(b + 21, SIG_TICK, 3'b010, 3'b010, "div0_tick_a");
        ex(b + 21, SIG_CLK,  3'b010, 3'b010, "div0_clk_a");
        ex(b + 23, SIG_TICK, 3'b010, 3'b010, "div0_tick_b");
        ex(b + 23, SIG_CLK,  3'b010, 3'b010, "div0_clk_b");
        at(b + 17);
        cfg_valid = 1'b0;

        // ch0 -> div 2 staged, then en[0] dropped: applies on the disabled edge
        at(b + 24);
        cfg(1'b1, 2'd0, 8'd2, 1'b0);
        ex(b + 24, SIG_CLK,  3'b101, 3'b001, "pre_dis_clk");
        ex(b + 25, SIG_PEND, 3'b001, 3'b001, "pend0_staged");
        ex(b + 25, SIG_CLK,  3'b001, 3'b001, "pre_dis_hold");
        ex(b + 26, SIG_CLK,  3'b001, 3'b000, "dis_clk");
        ex(b + 26, SIG_PEND, 3'b001, 3'b000, "dis_apply");
        ex(b + 26, SIG_TICK, 3'b001, 3'b000, "dis_tick");
        ex(b + 27, SIG_CLK,  3'b001, 3'b000, "dis_hold");
        ex(b + 29, SIG_TICK, 3'b001, 3'b000, "reen_no_early_tick");
        ex(b + 29, SIG_CLK,  3'b001, 3'b000, "reen_no_early_clk");
        ex(b + 30, SIG_TICK, 3'b001, 3'b001, "reen_first_tick");
        ex(b + 30, SIG_CLK,  3'b001, 3'b001, "reen_first_clk");
        at(b + 25);
        cfg_valid = 1'b0;
        en        = 3'b110;
        at(b + 27);
        en = 3'b111;

        // ch0 -> div 4 accepted on its own terminal edge
        at(b + 32);
        cfg(1'b1, 2'd0, 8'd4, 1'b0);
        ex(b + 32, SIG_RDY,  3'b001, 3'b001, "rdy_before_term");
        ex(b + 33, SIG_PEND, 3'b001, 3'b001, "coinc_pend");
        ex(b + 33, SIG_TICK, 3'b001, 3'b001, "coinc_tick");
        ex(b + 33, SIG_CLK,  3'b001, 3'b000, "coinc_clk");
        ex(b + 35, SIG_TICK, 3'b001, 3'b000, "old_div_gap");
        ex(b + 36, SIG_TICK, 3'b001, 3'b001, "old_div_term");
        ex(b + 36, SIG_PEND, 3'b001, 3'b000, "coinc_apply");
        ex(b + 36, SIG_CLK,  3'b001, 3'b001, "coinc_apply_clk");
        ex(b + 39, SIG_TICK, 3'b001, 3'b000, "new_div_gap");
        ex(b + 40, SIG_TICK, 3'b111, 3'b110, "indep_tick");
        ex(b + 40, SIG_CLK,  3'b111, 3'b011, "indep_clk");
        ex(b + 41, SIG_TICK, 3'b001, 3'b001, "new_div_term");
        ex(b + 41, SIG_CLK,  3'b001, 3'b000, "new_div_clk");
        at(b + 33);
        cfg_valid = 1'b0;

        // Out-of-range channel, then staged config wiped by an async reset
        at(b + 41);
        cfg(1'b1, 2'd3, 8'd7, 1'b1);
        ex(b + 41, SIG_RDY,  3'b001, 3'b001, "rdy_oob");
        ex(b + 43, SIG_PEND, 3'b111, 3'b000, "oob_no_pend");
        ex(b + 46, SIG_PEND, 3'b100, 3'b100, "pend2_staged");
        ex(b + 46, SIG_TICK, 3'b001, 3'b001, "oob_ch0_tick");
        ex(b + 46, SIG_CLK,  3'b001, 3'b001, "oob_ch0_clk");
        ex(b + 47, SIG_CLK,  3'b111, 3'b000, "async_rst_clk");
        ex(b + 47, SIG_TICK, 3'b111, 3'b000, "async_rst_tick");
        ex(b + 47, SIG_PEND, 3'b111, 3'b000, "async_rst_pend");
        at(b + 43);
        cfg(1'b0, 2'd0, 8'd0, 1'b0);
        at(b + 45);
        cfg(1'b1, 2'd2, 8'd1, 1'b0);
        at(b + 46);
        cfg_valid = 1'b0;
        at(b + 47);
        rst = 1'b1;
        at(b + 49);
        rst = 1'b0;
        c   = cyc;

        // Defaults restored: div 3, mode 0 on every channel
        ex(c,     SIG_CLK,  3'b111, 3'b000, "post_rst_clk");
        ex(c + 3, SIG_TICK, 3'b111, 3'b000, "post_rst_gap");
        ex(c + 4, SIG_TICK, 3'b111, 3'b111, "post_rst_tick");
        ex(c + 4, SIG_CLK,  3'b111, 3'b111, "post_rst_toggle");
        ex(c + 4, SIG_PEND, 3'b111, 3'b000, "post_rst_pend");
        ex(c + 5, SIG_CLK,  3'b111, 3'b111, "post_rst_mode0");
        ex(c + 5, SIG_TICK, 3'b111, 3'b000, "post_rst_tick_off");

        at(c + 8);
        while (q.size() > 0) begin
            me = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: check due at cycle %0d never reached", me.name, me.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
